// File: rtl/c5_mem_ctrl_pkg.sv
// Shared encodings for the c5 data-memory controller: access functions,
// controller states and helpers for classifying an access.
package c5_mem_ctrl_pkg;

    typedef enum logic [3:0] {
        MEM_NONE    = 4'd0,
        MEM_READ32  = 4'd1,
        MEM_READ16  = 4'd2,
        MEM_READ16S = 4'd3,
        MEM_READ8   = 4'd4,
        MEM_READ8S  = 4'd5,
        MEM_WRITE32 = 4'd6,
        MEM_WRITE16 = 4'd7,
        MEM_WRITE8  = 4'd8
    } mem_func_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int unsigned CNT_W = 8;

    // Undefined function codes are treated like MEM_NONE.
    function automatic logic is_mem_op(input logic [3:0] f);
        case (f)
            MEM_READ32, MEM_READ16, MEM_READ16S, MEM_READ8, MEM_READ8S,
            MEM_WRITE32, MEM_WRITE16, MEM_WRITE8: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] f, input logic [1:0] a);
        case (f)
            MEM_READ32, MEM_WRITE32:              return (a != 2'b00);
            MEM_READ16, MEM_READ16S, MEM_WRITE16: return a[0];
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_write(input mem_func_t f);
        return (f == MEM_WRITE32) || (f == MEM_WRITE16) || (f == MEM_WRITE8);
    endfunction

endpackage

// File: rtl/c5_mem_ctrl_if.sv
// System-bus side of the data-memory controller: request/acknowledge
// handshake, word address, byte enables and data in both directions.
interface c5_mem_ctrl_if;
    logic        O_bus_req;
    logic [29:0] O_bus_address;
    logic [3:0]  O_bus_byte_we;
    logic [31:0] O_bus_data_w;
    logic [31:0] I_bus_data_r;
    logic        I_bus_ack;

    modport master (
        output O_bus_req, O_bus_address, O_bus_byte_we, O_bus_data_w,
        input  I_bus_data_r, I_bus_ack
    );

    modport slave (
        input  O_bus_req, O_bus_address, O_bus_byte_we, O_bus_data_w,
        output I_bus_data_r, I_bus_ack
    );
endinterface

// File: rtl/c5_mem_align.sv
// Big-endian byte-lane steering: store data/enables toward the bus and
// sign/zero extension of load data coming back (byte 0 = bits 31:24).
module c5_mem_align
    import c5_mem_ctrl_pkg::*;
(
    input  mem_func_t   func,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data_write,
    input  logic [31:0] bus_data_r,
    output logic [31:0] lane_data_w,
    output logic [3:0]  byte_we,
    output logic [31:0] data_read
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        lane_data_w = data_write;
        byte_we     = '0;
        case (func)
            MEM_WRITE32: byte_we = 4'b1111;
            MEM_WRITE16: begin
                lane_data_w = {2{data_write[15:0]}};
                byte_we     = addr_lo[1] ? 4'b0011 : 4'b1100;
            end
            MEM_WRITE8: begin
                lane_data_w = {4{data_write[7:0]}};
                byte_we     = 4'b1000 >> addr_lo;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    rd_byte = bus_data_r[31:24];
            2'd1:    rd_byte = bus_data_r[23:16];
            2'd2:    rd_byte = bus_data_r[15:8];
            default: rd_byte = bus_data_r[7:0];
        endcase
        rd_half = addr_lo[1] ? bus_data_r[15:0] : bus_data_r[31:16];

        data_read = bus_data_r;
        case (func)
            MEM_READ16:  data_read = {16'h0000, rd_half};
            MEM_READ16S: data_read = {{16{rd_half[15]}}, rd_half};
            MEM_READ8:   data_read = {24'h000000, rd_byte};
            MEM_READ8S:  data_read = {{24{rd_byte[7]}}, rd_byte};
            default: ;
        endcase
    end

endmodule

// File: rtl/c5_mem_ctrl.sv
// CPU data-memory controller: issues one bus request/ack transaction per
// load/store, stalls the pipeline meanwhile, and flags misalignment/timeouts.
module c5_mem_ctrl
    import c5_mem_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             I_clk,
    input  logic             I_reset,
    input  logic [3:0]       I_mem_source,
    input  logic [WIDTH-1:0] I_address,
    input  logic [WIDTH-1:0] I_data_write,
    output logic [WIDTH-1:0] O_data_read,
    output logic             O_pause,
    output logic             O_exception,
    output logic             O_bus_error,
    c5_mem_ctrl_if.master    bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    mem_func_t        func_q, func_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic             req_q, req_d;
    logic [29:0]      bus_addr_q, bus_addr_d;
    logic [3:0]       we_q, we_d;
    logic [31:0]      data_w_q, data_w_d;
    logic [31:0]      data_read_q, data_read_d;
    logic             exception_q, exception_d;
    logic             bus_error_q, bus_error_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             pause;

    logic             start_ok;
    logic             start_bad;
    mem_func_t        al_func;
    logic [1:0]       al_addr_lo;
    logic [31:0]      al_data_w;
    logic [3:0]       al_we;
    logic [31:0]      al_data_r;

    assign start_ok  = is_mem_op(I_mem_source) && !is_misaligned(I_mem_source, I_address[1:0]);
    assign start_bad = is_mem_op(I_mem_source) &&  is_misaligned(I_mem_source, I_address[1:0]);

    // One aligner serves both directions: store lanes are only consumed in
    // IDLE (from the live request), load extension only in ACCESS (latched).
    assign al_func    = (state_q == IDLE) ? mem_func_t'(I_mem_source) : func_q;
    assign al_addr_lo = (state_q == IDLE) ? I_address[1:0] : addr_lo_q;

    c5_mem_align u_align (
        .func        (al_func),
        .addr_lo     (al_addr_lo),
        .data_write  (I_data_write[31:0]),
        .bus_data_r  (bus.I_bus_data_r),
        .lane_data_w (al_data_w),
        .byte_we     (al_we),
        .data_read   (al_data_r)
    );

    always_comb begin
        state_d     = state_q;
        func_d      = func_q;
        addr_lo_d   = addr_lo_q;
        req_d       = req_q;
        bus_addr_d  = bus_addr_q;
        we_d        = we_q;
        data_w_d    = data_w_q;
        data_read_d = data_read_q;
        exception_d = 1'b0;
        bus_error_d = 1'b0;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + 1'b1;
        pause       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    func_d     = mem_func_t'(I_mem_source);
                    addr_lo_d  = I_address[1:0];
                    bus_addr_d = I_address[31:2];
                    we_d       = al_we;
                    data_w_d   = al_data_w;
                    req_d      = 1'b1;
                    cnt_d      = '0;
                    pause      = 1'b1;
                    state_d    = ACCESS;
                end else if (start_bad) begin
                    exception_d = 1'b1;
                end
            end
            ACCESS: begin
                pause = 1'b1;
                if (bus.I_bus_ack) begin
                    req_d = 1'b0;
                    we_d  = '0;
                    if (!is_write(func_q)) begin
                        data_read_d = al_data_r;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_CNT) begin
                        req_d       = 1'b0;
                        we_d        = '0;
                        bus_error_d = 1'b1;
                        data_read_d = '0;
                        state_d     = DONE;
                    end
                end
            end
            // The request still shows the finished instruction here.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state_q     <= IDLE;
            func_q      <= MEM_NONE;
            addr_lo_q   <= '0;
            req_q       <= 1'b0;
            bus_addr_q  <= '0;
            we_q        <= '0;
            data_w_q    <= '0;
            data_read_q <= '0;
            exception_q <= 1'b0;
            bus_error_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            func_q      <= func_d;
            addr_lo_q   <= addr_lo_d;
            req_q       <= req_d;
            bus_addr_q  <= bus_addr_d;
            we_q        <= we_d;
            data_w_q    <= data_w_d;
            data_read_q <= data_read_d;
            exception_q <= exception_d;
            bus_error_q <= bus_error_d;
            cnt_q       <= cnt_d;
        end
    end

    // Pause is gated by reset so a request held during reset cannot stall.
    assign O_pause           = pause && !I_reset;
    assign O_exception       = exception_q;
    assign O_bus_error       = bus_error_q;
    assign O_data_read       = data_read_q;
    assign bus.O_bus_req     = req_q;
    assign bus.O_bus_address = bus_addr_q;
    assign bus.O_bus_byte_we = we_q;
    assign bus.O_bus_data_w  = data_w_q;

endmodule

// File: tb/tb_c5_mem_ctrl.sv
// Directed bench for c5_mem_ctrl: a CPU-like driver holds each access while
// paused and a bus slave acks after a chosen delay.
module tb_c5_mem_ctrl;
    import c5_mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_source;
    logic [31:0] address;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        pause;
    logic        exception;
    logic        bus_error;

    int checks   = 0;
    int failures = 0;

    c5_mem_ctrl_if bus_if ();

    c5_mem_ctrl #(.WIDTH(32), .TIMEOUT(255)) dut (
        .I_clk        (clk),
        .I_reset      (rst),
        .I_mem_source (mem_source),
        .I_address    (address),
        .I_data_write (data_write),
        .O_data_read  (data_read),
        .O_pause      (pause),
        .O_exception  (exception),
        .O_bus_error  (bus_error),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    // Observations collected by run_access
    int          o_pause_cyc, o_req_cyc, o_post_req, o_exc_cyc, o_berr_cyc;
    logic [29:0] o_baddr;
    logic [3:0]  o_we, o_post_we;
    logic [31:0] o_dw, o_dread;
    logic        o_timed_out;

    // Drives one instruction; ack_delay = extra req cycles before ack, -1 = never.
    task automatic run_access(input logic [3:0] f, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int ack_delay);
        o_pause_cyc = 0; o_req_cyc = 0; o_post_req = 0; o_exc_cyc = 0;
        o_berr_cyc = 0; o_baddr = '0; o_we = '0; o_post_we = '0;
        o_dw = '0; o_dread = '0; o_timed_out = 1'b1;
        @(negedge clk);
        mem_source = f; address = a; data_write = wd;
        bus_if.I_bus_data_r = rd; bus_if.I_bus_ack = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            #1;
            if (exception) o_exc_cyc++;
            if (bus_error) o_berr_cyc++;
            if (pause) o_pause_cyc++;
            if (bus_if.O_bus_req) begin
                o_req_cyc++;
                o_baddr = bus_if.O_bus_address;
                o_we    = bus_if.O_bus_byte_we;
                o_dw    = bus_if.O_bus_data_w;
                bus_if.I_bus_ack = (o_req_cyc - 1 == ack_delay);
            end else begin
                bus_if.I_bus_ack = 1'b0;
            end
            if (!pause) begin
                o_dread = data_read;
                o_timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            mem_source = MEM_NONE; bus_if.I_bus_ack = 1'b0;
            #1;
            if (exception) o_exc_cyc++;
            if (bus_error) o_berr_cyc++;
            if (bus_if.O_bus_req) o_post_req++;
            o_post_we = o_post_we | bus_if.O_bus_byte_we;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_source = MEM_READ32; address = 32'h0000_1000;
        data_write = 32'hFFFF_FFFF;
        bus_if.I_bus_ack = 1'b0; bus_if.I_bus_data_r = 32'h1111_1111;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (pause !== 1'b0) begin failures++; $display("FAIL reset_pause: got %b expected 0", pause); end
        checks++; if (bus_if.O_bus_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", bus_if.O_bus_req); end
        checks++; if (bus_if.O_bus_byte_we !== 4'b0000) begin failures++; $display("FAIL reset_we: got %b expected 0000", bus_if.O_bus_byte_we); end
        checks++; if (bus_if.O_bus_address !== 30'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", bus_if.O_bus_address); end
        checks++; if (bus_if.O_bus_data_w !== 32'h0) begin failures++; $display("FAIL reset_dw: got %h expected 0", bus_if.O_bus_data_w); end
        checks++; if (data_read !== 32'h0) begin failures++; $display("FAIL reset_dread: got %h expected 0", data_read); end
        checks++; if ({exception, bus_error} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b expected 00", {exception, bus_error}); end
        mem_source = MEM_NONE;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read32();
        run_access(MEM_READ32, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0);
        checks++; if (o_timed_out !== 1'b0) begin failures++; $display("FAIL rd32_hang: got %b expected 0", o_timed_out); end
        checks++; if (o_baddr !== 30'h400) begin failures++; $display("FAIL rd32_addr: got %h expected 400", o_baddr); end
        checks++; if (o_pause_cyc !== 2) begin failures++; $display("FAIL rd32_pause_cycles: got %0d expected 2", o_pause_cyc); end
        checks++; if (o_req_cyc !== 1) begin failures++; $display("FAIL rd32_req_cycles: got %0d expected 1", o_req_cyc); end
        checks++; if (o_dread !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd32_data: got %h expected deadbeef", o_dread); end
        checks++; if (o_we !== 4'b0000) begin failures++; $display("FAIL rd32_we: got %b expected 0000", o_we); end
        checks++; if (o_post_req !== 0) begin failures++; $display("FAIL rd32_done_ignores_source: got %0d expected 0", o_post_req); end
    endtask

    task automatic test_read_ext();
        run_access(MEM_READ8S, 32'h0000_1003, 32'h0, 32'h1234_56F0, 0);
        checks++; if (o_dread !== 32'hFFFF_FFF0) begin failures++; $display("FAIL rd8s: got %h expected fffffff0", o_dread); end
        run_access(MEM_READ8, 32'h0000_1003, 32'h0, 32'h1234_56F0, 2);
        checks++; if (o_dread !== 32'h0000_00F0) begin failures++; $display("FAIL rd8: got %h expected 000000f0", o_dread); end
        checks++; if (o_pause_cyc !== 4) begin failures++; $display("FAIL rd8_delayed_pause: got %0d expected 4", o_pause_cyc); end
        run_access(MEM_READ16, 32'h0000_1000, 32'h0, 32'h1234_56F0, 0);
        checks++; if (o_dread !== 32'h0000_1234) begin failures++; $display("FAIL rd16: got %h expected 00001234", o_dread); end
        run_access(MEM_READ16S, 32'h0000_1002, 32'h0, 32'h1234_8001, 0);
        checks++; if (o_dread !== 32'hFFFF_8001) begin failures++; $display("FAIL rd16s: got %h expected ffff8001", o_dread); end
        run_access(MEM_READ8, 32'h0000_1001, 32'h0, 32'hAA9B_CCDD, 0);
        checks++; if (o_dread !== 32'h0000_009B) begin failures++; $display("FAIL rd8_lane1: got %h expected 0000009b", o_dread); end
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        bus_if.I_bus_data_r = 32'h7777_7777; bus_if.I_bus_ack = 1'b1;
        @(negedge clk);
        bus_if.I_bus_ack = 1'b0;
        #1;
        checks++; if (data_read !== 32'h0000_009B) begin failures++; $display("FAIL idle_ack_data: got %h expected 0000009b", data_read); end
        checks++; if (bus_if.O_bus_req !== 1'b0) begin failures++; $display("FAIL idle_ack_req: got %b expected 0", bus_if.O_bus_req); end
    endtask

    task automatic test_write();
        run_access(MEM_WRITE8, 32'h0000_2001, 32'h0000_00AB, 32'h5555_5555, 0);
        checks++; if (o_we !== 4'b0100) begin failures++; $display("FAIL wr8_we: got %b expected 0100", o_we); end
        checks++; if (o_dw !== 32'hABAB_ABAB) begin failures++; $display("FAIL wr8_data: got %h expected abababab", o_dw); end
        checks++; if (o_baddr !== 30'h800) begin failures++; $display("FAIL wr8_addr: got %h expected 800", o_baddr); end
        checks++; if (o_dread !== 32'h0000_009B) begin failures++; $display("FAIL wr8_keeps_dread: got %h expected 0000009b", o_dread); end
        checks++; if (o_post_we !== 4'b0000) begin failures++; $display("FAIL wr8_we_drop: got %b expected 0000", o_post_we); end
        run_access(MEM_WRITE16, 32'h0000_2002, 32'h0000_CAFE, 32'h5555_5555, 0);
        checks++; if (o_we !== 4'b0011) begin failures++; $display("FAIL wr16_we: got %b expected 0011", o_we); end
        checks++; if (o_dw !== 32'hCAFE_CAFE) begin failures++; $display("FAIL wr16_data: got %h expected cafecafe", o_dw); end
        run_access(MEM_WRITE8, 32'h0000_2003, 32'h1234_5667, 32'h0, 0);
        checks++; if (o_we !== 4'b0001) begin failures++; $display("FAIL wr8_lane3_we: got %b expected 0001", o_we); end
    endtask

    task automatic test_misaligned();
        run_access(MEM_READ32, 32'h0000_1002, 32'h0, 32'h0, 0);
        checks++; if (o_exc_cyc !== 1) begin failures++; $display("FAIL mis32_exc: got %0d expected 1", o_exc_cyc); end
        checks++; if (o_req_cyc + o_post_req !== 0) begin failures++; $display("FAIL mis32_req: got %0d expected 0", o_req_cyc + o_post_req); end
        checks++; if (o_pause_cyc !== 0) begin failures++; $display("FAIL mis32_pause: got %0d expected 0", o_pause_cyc); end
        run_access(MEM_WRITE16, 32'h0000_2001, 32'h0000_BEEF, 32'h0, 0);
        checks++; if (o_exc_cyc !== 1) begin failures++; $display("FAIL mis16_exc: got %0d expected 1", o_exc_cyc); end
        checks++; if (o_req_cyc + o_post_req !== 0) begin failures++; $display("FAIL mis16_req: got %0d expected 0", o_req_cyc + o_post_req); end
    endtask

    task automatic test_timeout();
        run_access(MEM_READ32, 32'h0000_1000, 32'h0, 32'h0BAD_F00D, -1);
        checks++; if (o_timed_out !== 1'b0) begin failures++; $display("FAIL tmo_hang: got %b expected 0", o_timed_out); end
        checks++; if (o_req_cyc !== 255) begin failures++; $display("FAIL tmo_req_cycles: got %0d expected 255", o_req_cyc); end
        checks++; if (o_pause_cyc !== 256) begin failures++; $display("FAIL tmo_pause_cycles: got %0d expected 256", o_pause_cyc); end
        checks++; if (o_berr_cyc !== 1) begin failures++; $display("FAIL tmo_bus_error: got %0d expected 1", o_berr_cyc); end
        checks++; if (o_dread !== 32'h0) begin failures++; $display("FAIL tmo_data: got %h expected 0", o_dread); end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        mem_source = MEM_WRITE32; address = 32'h0000_3000; data_write = 32'hA5A5_A5A5;
        bus_if.I_bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus_if.O_bus_byte_we !== 4'b1111) begin failures++; $display("FAIL mid_we_before: got %b expected 1111", bus_if.O_bus_byte_we); end
        rst = 1'b1;
        #1;
        checks++; if (bus_if.O_bus_req !== 1'b0) begin failures++; $display("FAIL mid_req_drop: got %b expected 0", bus_if.O_bus_req); end
        checks++; if (bus_if.O_bus_byte_we !== 4'b0000) begin failures++; $display("FAIL mid_we_drop: got %b expected 0000", bus_if.O_bus_byte_we); end
        checks++; if (pause !== 1'b0) begin failures++; $display("FAIL mid_pause_drop: got %b expected 0", pause); end
        @(negedge clk);
        mem_source = MEM_NONE;
        @(negedge clk);
        rst = 1'b0;
        run_access(MEM_WRITE32, 32'h0000_3004, 32'h1122_3344, 32'h0, 1);
        checks++; if (o_we !== 4'b1111) begin failures++; $display("FAIL post_rst_we: got %b expected 1111", o_we); end
        checks++; if (o_dw !== 32'h1122_3344) begin failures++; $display("FAIL post_rst_data: got %h expected 11223344", o_dw); end
        checks++; if (o_baddr !== 30'hC01) begin failures++; $display("FAIL post_rst_addr: got %h expected c01", o_baddr); end
        checks++; if (o_pause_cyc !== 3) begin failures++; $display("FAIL post_rst_pause: got %0d expected 3", o_pause_cyc); end
    endtask

    initial begin
        test_reset();
        test_read32();
        test_read_ext();
        test_stray_ack();
        test_write();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
